// File: rtl/definitions.sv
// Shared widths, pipeline state encoding and entry layout for the XM stage.
package definitions;

  localparam int unsigned XM_DATA_W = 32;
  localparam int unsigned XM_ADDR_W = 5;
  localparam int unsigned XM_CTRL_W = 8;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_FULL,
    PS_SKID
  } pipe_state_e;

  typedef struct packed {
    logic [XM_CTRL_W-1:0] ctrl;
    logic [XM_ADDR_W-1:0] dst;
    logic [XM_DATA_W-1:0] addr;
    logic [XM_DATA_W-1:0] val;
  } xm_entry_t;

endpackage

// File: rtl/fwd_prio_sel.sv
// Store-data forwarding mux: the lowest-indexed requesting source wins,
// otherwise the unforwarded rt value passes through.
module fwd_prio_sel #(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0]         rt_val,
  output logic [DATA_W-1:0]         sel_val
);

  logic found;

  // Priority scan from source 0 upward; first hit locks the result.
  always_comb begin
    sel_val = rt_val;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_en[i]) begin
        sel_val = fwd_data[i*DATA_W +: DATA_W];
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xm_pipe_stage.sv
// Execute-to-memory pipeline stage with forwarding, valid/ready flow control,
// optional 2-entry skid buffer, flush and a saturating back-pressure counter.
module xm_pipe_stage
  import definitions::*;
#(
  parameter int unsigned DATA_W  = XM_DATA_W,
  parameter int unsigned ADDR_W  = XM_ADDR_W,
  parameter int unsigned CTRL_W  = XM_CTRL_W,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [ADDR_W-1:0]         in_dst,
  input  logic [DATA_W-1:0]         in_alu,
  input  logic [DATA_W-1:0]         in_rt,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [ADDR_W-1:0]         out_dst,
  output logic [DATA_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_val,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Same layout as xm_entry_t but sized by this instance's parameters.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } entry_t;

  pipe_state_e      state_q, state_d;
  entry_t           m_q, m_d, s_q, s_d;
  entry_t           new_e;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] st_val;
  logic             m_valid;
  logic             accept;
  logic             consume;

  fwd_prio_sel #(
    .NUM_FWD (NUM_FWD),
    .DATA_W  (DATA_W)
  ) u_fwd_sel (
    .fwd_en   (fwd_en),
    .fwd_data (fwd_data),
    .rt_val   (in_rt),
    .sel_val  (st_val)
  );

  assign new_e   = '{ctrl: in_ctrl, dst: in_dst, addr: in_alu, val: st_val};
  assign m_valid = (state_q != PS_EMPTY) && !rst;
  assign accept  = in_valid && in_ready;
  assign consume = m_valid && out_ready;

  // Ready: registered in skid mode, pass-through of downstream ready otherwise.
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = in_ready_q && !rst;
    end else begin
      in_ready = (!m_valid || out_ready) && !rst;
    end
  end

  // Next-state: M always holds the oldest entry, S only fills while M is stuck.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          m_d     = new_e;
          state_d = PS_FULL;
        end
      end
      PS_FULL: begin
        if (accept && consume) begin
          m_d = new_e;
        end else if (accept) begin
          s_d     = new_e;
          state_d = PS_SKID;
        end else if (consume) begin
          state_d = PS_EMPTY;
        end
      end
      PS_SKID: begin
        if (consume) begin
          m_d     = s_q;
          state_d = PS_FULL;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    // Flush drops everything, including an entry accepted this cycle.
    if (flush) begin
      state_d = PS_EMPTY;
    end
    in_ready_d = (state_d != PS_SKID);
  end

  // Back-pressure counter saturates at all-ones; flush leaves it alone.
  always_comb begin
    cnt_d = cnt_q;
    if (m_valid && !out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PS_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs read zero while reset is held; ctrl is also masked when invalid.
  always_comb begin
    out_valid = m_valid;
    out_ctrl  = m_valid ? m_q.ctrl : '0;
    out_dst   = rst ? '0 : m_q.dst;
    out_addr  = rst ? '0 : m_q.addr;
    out_val   = rst ? '0 : m_q.val;
    stall_cnt = rst ? '0 : cnt_q;
  end

endmodule

// File: tb/tb_xm_pipe_stage.sv
// Directed bench for xm_pipe_stage: skid (a), non-skid (b) and 4-bit counter (c)
// instances share one set of inputs; each test checks the instance it targets.
module tb_xm_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [4:0]  in_dst;
  logic [31:0] in_alu;
  logic [31:0] in_rt;
  logic [1:0]  fwd_en;
  logic [63:0] fwd_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_ctrl;
  logic [4:0]  a_out_dst;
  logic [31:0] a_out_addr, a_out_val;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_ctrl;
  logic [4:0]  b_out_dst;
  logic [31:0] b_out_addr, b_out_val;
  logic [15:0] b_stall;

  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_out_ctrl;
  logic [4:0]  c_out_dst;
  logic [31:0] c_out_addr, c_out_val;
  logic [3:0]  c_stall;

  int tests = 0;
  int fails = 0;

  logic [1:0]  fwd_ens [3] = '{2'b11, 2'b10, 2'b00};
  logic [31:0] fwd_exp [3] = '{32'h22, 32'h33, 32'h11};

  always #5 clk = ~clk;

  xm_pipe_stage #(.SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_dst(in_dst), .in_alu(in_alu), .in_rt(in_rt),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_dst(a_out_dst),
    .out_addr(a_out_addr), .out_val(a_out_val), .stall_cnt(a_stall)
  );

  xm_pipe_stage #(.SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_dst(in_dst), .in_alu(in_alu), .in_rt(in_rt),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_dst(b_out_dst),
    .out_addr(b_out_addr), .out_val(b_out_val), .stall_cnt(b_stall)
  );

  xm_pipe_stage #(.SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_dst(in_dst), .in_alu(in_alu), .in_rt(in_rt),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_ctrl(c_out_ctrl), .out_dst(c_out_dst),
    .out_addr(c_out_addr), .out_val(c_out_val), .stall_cnt(c_stall)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] d);
    in_valid = v;
    in_dst   = d;
    in_ctrl  = {3'b101, d};
    in_alu   = 32'h1000 + {27'h0, d};
    in_rt    = 32'h11;
    fwd_en   = 2'b00;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    put(1'b0, 5'd0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_data = 64'h0;
    put(1'b0, 5'd0);
    cyc(); cyc();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", a_out_valid); end
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", a_in_ready); end
    tests++; if (b_in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_b got %b want 0", b_in_ready); end
    tests++; if (a_stall !== 16'd0) begin fails++; $display("FAIL rst_stall got %0d want 0", a_stall); end
    tests++; if (a_out_ctrl !== 8'h0) begin fails++; $display("FAIL rst_ctrl got %h want 0", a_out_ctrl); end
    rst = 1'b0;
    #1;
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b want 1", a_in_ready); end
    tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready_b got %b want 1", b_in_ready); end
  endtask

  task automatic test_fwd();
    do_reset();
    out_ready = 1'b1;
    fwd_data  = {32'h33, 32'h22};
    for (int k = 0; k < 3; k++) begin
      put(1'b1, 5'(k + 1));
      fwd_en = fwd_ens[k];
      cyc();
      tests++; if (a_out_val !== fwd_exp[k]) begin fails++; $display("FAIL fwd_a%0d got %h want %h", k, a_out_val, fwd_exp[k]); end
      tests++; if (b_out_val !== fwd_exp[k]) begin fails++; $display("FAIL fwd_b%0d got %h want %h", k, b_out_val, fwd_exp[k]); end
    end
    put(1'b0, 5'd0);
    cyc();
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 1'b0;
    put(1'b1, 5'd1); cyc();
    tests++; if (a_out_dst !== 5'd1 || a_out_ctrl !== 8'hA1) begin fails++; $display("FAIL bp_A got dst %0d ctrl %h want 1 a1", a_out_dst, a_out_ctrl); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_A got %b want 1", a_in_ready); end
    put(1'b1, 5'd2); cyc();
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_B got %b want 0", a_in_ready); end
    tests++; if (a_stall !== 16'd1) begin fails++; $display("FAIL bp_stall1 got %0d want 1", a_stall); end
    put(1'b1, 5'd3); cyc();
    tests++; if (a_stall !== 16'd2 || a_out_dst !== 5'd1) begin fails++; $display("FAIL bp_stall2 got %0d dst %0d want 2 1", a_stall, a_out_dst); end
    cyc();
    tests++; if (a_stall !== 16'd3 || a_in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall3 got %0d rdy %b want 3 0", a_stall, a_in_ready); end
    out_ready = 1'b1; cyc();
    tests++; if (a_out_dst !== 5'd2 || a_in_ready !== 1'b1) begin fails++; $display("FAIL bp_drainB got dst %0d rdy %b want 2 1", a_out_dst, a_in_ready); end
    tests++; if (a_stall !== 16'd3) begin fails++; $display("FAIL bp_stall_hold got %0d want 3", a_stall); end
    cyc();
    tests++; if (a_out_dst !== 5'd3 || a_out_valid !== 1'b1) begin fails++; $display("FAIL bp_drainC got dst %0d v %b want 3 1", a_out_dst, a_out_valid); end
    put(1'b0, 5'd0); cyc();
    tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h0) begin fails++; $display("FAIL bp_empty got v %b ctrl %h want 0 0", a_out_valid, a_out_ctrl); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 5'(i));
      #1;
      tests++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b %b want 1 1", i, a_in_ready, b_in_ready); end
      cyc();
      tests++; if (a_out_dst !== 5'(i) || a_out_valid !== 1'b1) begin fails++; $display("FAIL b2b_a%0d got dst %0d v %b want %0d 1", i, a_out_dst, a_out_valid, i); end
      tests++; if (b_out_dst !== 5'(i) || b_out_valid !== 1'b1) begin fails++; $display("FAIL b2b_b%0d got dst %0d v %b want %0d 1", i, b_out_dst, b_out_valid, i); end
    end
    put(1'b0, 5'd0); cyc();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", a_out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    put(1'b1, 5'd1); cyc();
    put(1'b1, 5'd2); cyc();
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL fl_skid got rdy %b want 0", a_in_ready); end
    flush = 1'b1; out_ready = 1'b1;
    put(1'b1, 5'd9); cyc();
    tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h0) begin fails++; $display("FAIL fl_out got v %b ctrl %h want 0 0", a_out_valid, a_out_ctrl); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL fl_ready got %b want 1", a_in_ready); end
    tests++; if (a_stall !== 16'd1) begin fails++; $display("FAIL fl_stall got %0d want 1", a_stall); end
    tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL fl_discard_b got %b want 0", b_out_valid); end
    flush = 1'b0;
    put(1'b0, 5'd0); cyc();
    tests++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin fails++; $display("FAIL fl_absent got %b %b want 0 0", a_out_valid, b_out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    put(1'b1, 5'd3); cyc();
    put(1'b0, 5'd0); cyc();
    tests++; if (a_stall !== 16'd1 || a_out_valid !== 1'b1) begin fails++; $display("FAIL rm_pre got %0d v %b want 1 1", a_stall, a_out_valid); end
    rst = 1'b1; #1;
    tests++; if (a_out_valid !== 1'b0 || a_out_dst !== 5'd0 || a_out_addr !== 32'h0) begin fails++; $display("FAIL rm_out got v %b dst %0d addr %h want 0", a_out_valid, a_out_dst, a_out_addr); end
    tests++; if (a_out_val !== 32'h0 || a_out_ctrl !== 8'h0) begin fails++; $display("FAIL rm_data got val %h ctrl %h want 0", a_out_val, a_out_ctrl); end
    tests++; if (a_in_ready !== 1'b0 || a_stall !== 16'd0) begin fails++; $display("FAIL rm_ctl got rdy %b stall %0d want 0 0", a_in_ready, a_stall); end
    cyc();
    rst = 1'b0; #1;
    tests++; if (a_in_ready !== 1'b1 || a_stall !== 16'd0 || a_out_valid !== 1'b0) begin fails++; $display("FAIL rm_after got rdy %b stall %0d v %b want 1 0 0", a_in_ready, a_stall, a_out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    put(1'b1, 5'd4); cyc();
    put(1'b0, 5'd0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 10 || k == 15 || k == 20) begin
        tests++;
        if (c_stall !== 4'((k > 15) ? 15 : k)) begin
          fails++; $display("FAIL sat_c%0d got %0d want %0d", k, c_stall, (k > 15) ? 15 : k);
        end
      end
    end
    tests++; if (a_stall !== 16'd20) begin fails++; $display("FAIL sat_a got %0d want 20", a_stall); end
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
